dmem_arbiter: RTL

- Shares the single-port data memory between two requesters: port 0 is the core load/store unit and port 1 is the debug/DMA loader.
- Each cycle it grants at most one requester using round-robin priority.
- It supports a bounded lock so a requester can hold the memory across a read-modify-write sequence.
- It drives the memory's we/a/wd inputs and returns the read data registered, with a response valid one cycle after the grant.

---
 rtl/dmem_pkg.sv | 16 +
 rtl/dmem_arbiter_rr_arb2.sv | 43 ++++
 rtl/dmem_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and address-legality helper for the data-memory arbiter slice.
package dmem_pkg;

  localparam int DMEM_AW          = 32;
  localparam int DMEM_DW          = 32;
  localparam int DMEM_DEPTH_WORDS = 64;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Word aligned and inside the implemented word range; callers zero-extend to 64 bits.
  function automatic logic legal_addr(input logic [63:0] addr, input int depth);
    return (addr[1:0] == 2'b00) && ({2'b00, addr[63:2]} < 64'(depth));
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin grant with a lock override; remembers the last granted port.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic lock_valid,
  input  logic lock_owner,
  output logic gnt0,
  output logic gnt1,
  output logic last_gnt
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (lock_valid && (lock_owner == PORT_CPU) && req0) begin
      gnt0 = 1'b1;
    end else if (lock_valid && (lock_owner == PORT_DBG) && req1) begin
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      // Contention: the port that did not win last time goes now.
      if (last_gnt == PORT_CPU) gnt1 = 1'b1;
      else                      gnt0 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_gnt <= PORT_CPU;
    end else if (gnt0) begin
      last_gnt <= PORT_CPU;
    end else if (gnt1) begin
      last_gnt <= PORT_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core LSU (port 0) and the debug/DMA loader (port 1).
// Grants are combinational; read data, response valid and error are registered one cycle later.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW          = DMEM_AW,
  parameter int DW          = DMEM_DW,
  parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS,
  parameter int MAX_LOCK    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          err0,
  output logic          err1,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int CW = $clog2(MAX_LOCK) + 1;

  logic          lock_owner_valid;
  logic          lock_owner;
  logic [CW-1:0] lock_cnt;
  logic          last_gnt;

  logic          gnt_any;
  logic          gnt_port;
  logic          sel_we;
  logic          sel_lock;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wd;
  logic          legal;
  logic [CW:0]   next_cnt;

  rr_arb2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .lock_valid (lock_owner_valid),
    .lock_owner (lock_owner),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .last_gnt   (last_gnt)
  );

  always_comb begin
    gnt_any  = gnt0 | gnt1;
    gnt_port = gnt1 ? PORT_DBG : PORT_CPU;
    sel_we   = gnt1 ? we1    : we0;
    sel_lock = gnt1 ? lock1  : lock0;
    sel_addr = gnt1 ? addr1  : addr0;
    sel_wd   = gnt1 ? wdata1 : wdata0;
    legal    = legal_addr(64'(sel_addr), DEPTH_WORDS);
    mem_we   = gnt_any & sel_we & legal;
    mem_a    = gnt_any ? sel_addr : '0;
    mem_wd   = gnt_any ? sel_wd   : '0;
    // A grant to a port other than the current owner starts a fresh lock run.
    if (lock_owner_valid && (lock_owner == gnt_port)) next_cnt = {1'b0, lock_cnt} + 1'b1;
    else                                              next_cnt = (CW+1)'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_owner_valid <= 1'b0;
      lock_owner       <= PORT_CPU;
      lock_cnt         <= '0;
    end else if (gnt_any && sel_lock && (next_cnt < (CW+1)'(MAX_LOCK))) begin
      lock_owner_valid <= 1'b1;
      lock_owner       <= gnt_port;
      lock_cnt         <= next_cnt[CW-1:0];
    end else begin
      lock_owner_valid <= 1'b0;
      lock_cnt         <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
      if (gnt_any) begin
        if (gnt_port == PORT_CPU) err0 <= ~legal;
        else                      err1 <= ~legal;
        if (!sel_we) begin
          if (gnt_port == PORT_CPU) rvalid0 <= 1'b1;
          else                      rvalid1 <= 1'b1;
          // Illegal reads never expose memory contents.
          rdata <= legal ? mem_rd : '0;
        end
      end
    end
  end

endmodule
